// File: rtl/ram_8x8_pkg.sv
// ram_8x8_pkg: shared constants and types for the 8x8 simple dual-port RAM.
//   DATA_W - data width in bits
//   ADDR_W - address width in bits
//   DEPTH  - number of words, always 2**ADDR_W
package ram_8x8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Whole storage array as one packed value so it can cross a port boundary.
    typedef data_t [DEPTH-1:0] mem_t;

endpackage : ram_8x8_pkg

// File: rtl/ram_8x8_rd_port.sv
// ram_8x8_rd_port: read mux, optional write-first bypass, and data_out register.
// Optional feature macro: RAM_8X8_BYPASS_EN (same-edge, same-address read returns
// the data being written; without it the pre-write contents are returned).
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears data_out
//   mem      - current storage contents from the top
//   rd_enb   - read enable; data_out holds when low
//   rd_addr  - read address
//   wr_enb   - write enable (bypass build only)
//   wr_addr  - write address (bypass build only)
//   data_in  - write data (bypass build only)
//   data_out - registered read data
module ram_8x8_rd_port
    import ram_8x8_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  mem_t  mem,
    input  logic  rd_enb,
    input  addr_t rd_addr,
`ifdef RAM_8X8_BYPASS_EN
    input  logic  wr_enb,
    input  addr_t wr_addr,
    input  data_t data_in,
`endif
    output data_t data_out
);

    data_t rd_data_c;

    // Select the addressed word; forward the incoming write when it targets it.
    always_comb begin
        rd_data_c = mem[rd_addr];
`ifdef RAM_8X8_BYPASS_EN
        if (wr_enb && (wr_addr == rd_addr)) begin
            rd_data_c = data_in;
        end
`endif
    end

    // Output register: updates only on an enabled read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_enb) begin
            data_out <= rd_data_c;
        end
    end

endmodule : ram_8x8_rd_port

// File: rtl/ram_8x8.sv
// ram_8x8: 8-entry x 8-bit simple dual-port RAM, synchronous write,
// registered read with one cycle of latency.
// Optional feature macro: RAM_8X8_BYPASS_EN (write-first forwarding on a
// same-edge, same-address read and write).
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset, clears memory and data_out
//   wr_enb   - write enable
//   wr_addr  - write address
//   data_in  - write data
//   rd_enb   - read enable
//   rd_addr  - read address
//   data_out - registered read data
module ram_8x8
    import ram_8x8_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_enb,
    input  addr_t wr_addr,
    input  data_t data_in,
    input  logic  rd_enb,
    input  addr_t rd_addr,
    output data_t data_out
);

    mem_t              mem;
    logic [DEPTH-1:0]  wr_sel_c;

    // Write decoder: one-hot word select, all zero when writes are disabled.
    always_comb begin
        wr_sel_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_sel_c[i] = wr_enb && (wr_addr == ADDR_W'(i));
        end
    end

    // Storage array: async-clearable flops, one word updated per write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_sel_c[i]) begin
                    mem[i] <= data_in;
                end
            end
        end
    end

    // Read side sees the pre-edge array, giving read-old behaviour by default.
    ram_8x8_rd_port u_rd_port (
        .clk      (clk),
        .rst      (rst),
        .mem      (mem),
        .rd_enb   (rd_enb),
        .rd_addr  (rd_addr),
`ifdef RAM_8X8_BYPASS_EN
        .wr_enb   (wr_enb),
        .wr_addr  (wr_addr),
        .data_in  (data_in),
`endif
        .data_out (data_out)
    );

endmodule : ram_8x8

// File: tb/tb_ram_8x8.sv
// tb_ram_8x8: self-checking bench for ram_8x8 against an array-based model.
module tb_ram_8x8;

    logic       clk;
    logic       rst;
    logic       wr_enb;
    logic [2:0] wr_addr;
    logic [7:0] data_in;
    logic       rd_enb;
    logic [2:0] rd_addr;
    logic [7:0] data_out;

    int n_checks;
    int n_fail;

    // Reference: what the RAM should hold and what the last read returned.
    logic [7:0] model_mem [8];
    logic [7:0] model_out;

    ram_8x8 dut (
        .clk      (clk),
        .rst      (rst),
        .wr_enb   (wr_enb),
        .wr_addr  (wr_addr),
        .data_in  (data_in),
        .rd_enb   (rd_enb),
        .rd_addr  (rd_addr),
        .data_out (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
        model_out = 8'h00;
    endtask

    // One rising edge, model updated from the inputs present at that edge;
    // returns at the following falling edge so outputs are sampled mid-cycle.
    task automatic cycle();
        logic [7:0] nxt;
        @(posedge clk);
        nxt = model_out;
        if (rd_enb) begin
            nxt = model_mem[rd_addr];
`ifdef RAM_8X8_BYPASS_EN
            if (wr_enb && wr_addr == rd_addr) nxt = data_in;
`endif
        end
        if (wr_enb) model_mem[wr_addr] = data_in;
        model_out = nxt;
        @(negedge clk);
    endtask

    task automatic idle();
        wr_enb = 1'b0;
        rd_enb = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wr_enb = 1'b1; wr_addr = a; data_in = d; rd_enb = 1'b0;
        cycle();
        idle();
    endtask

    task automatic do_read(input logic [2:0] a);
        wr_enb = 1'b0; rd_enb = 1'b1; rd_addr = a;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_enb = 1'b0; rd_enb = 1'b0;
        wr_addr = 3'd0; rd_addr = 3'd0; data_in = 8'h00;
        model_clear();
        #12;
        rst = 1'b0;
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 00", data_out);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            n_checks++;
            if (data_out !== 8'h00 || data_out !== model_out) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h want 00", i, data_out);
            end
        end
    endtask

    task automatic test_write_read();
        logic [2:0] addrs [3];
        logic [7:0] vals  [3];
        addrs = '{3'd3, 3'd4, 3'd7};
        vals  = '{8'd11, 8'd22, 8'd77};
        // Back-to-back writes, one per edge, no gaps.
        for (int i = 0; i < 3; i++) begin
            wr_enb = 1'b1; wr_addr = addrs[i]; data_in = vals[i];
            cycle();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i]);
            n_checks++;
            if (data_out !== vals[i] || data_out !== model_out) begin
                n_fail++;
                $display("FAIL write_read@%0d: got %0d want %0d", addrs[i], data_out, vals[i]);
            end
        end
    endtask

    task automatic test_hold();
        rd_enb = 1'b0; rd_addr = 3'd3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (data_out !== 8'd77 || data_out !== model_out) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %0d want 77", i, data_out);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_out: got %h want 00", data_out);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [2:0] a;
            a = (i == 0) ? 3'd3 : (i == 1) ? 3'd4 : 3'd7;
            do_read(a);
            n_checks++;
            if (data_out !== 8'h00 || data_out !== model_out) begin
                n_fail++;
                $display("FAIL async_reset_read@%0d: got %h want 00", a, data_out);
            end
        end
    endtask

    task automatic test_collision();
        logic [7:0] want;
        do_write(3'd5, 8'h10);
        wr_enb = 1'b1; wr_addr = 3'd5; data_in = 8'hA5;
        rd_enb = 1'b1; rd_addr = 3'd5;
        cycle();
        idle();
`ifdef RAM_8X8_BYPASS_EN
        want = 8'hA5;
`else
        want = 8'h10;
`endif
        n_checks++;
        if (data_out !== want || data_out !== model_out) begin
            n_fail++;
            $display("FAIL collision: got %h want %h", data_out, want);
        end
        do_read(3'd5);
        n_checks++;
        if (data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL collision_after: got %h want a5", data_out);
        end
        // Collision on different addresses: both happen independently.
        do_write(3'd2, 8'h3C);
        wr_enb = 1'b1; wr_addr = 3'd6; data_in = 8'h99;
        rd_enb = 1'b1; rd_addr = 3'd2;
        cycle();
        idle();
        n_checks++;
        if (data_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL diff_addr_read: got %h want 3c", data_out);
        end
        do_read(3'd6);
        n_checks++;
        if (data_out !== 8'h99) begin
            n_fail++;
            $display("FAIL diff_addr_write: got %h want 99", data_out);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            wr_enb = 1'b1; wr_addr = 3'(i); data_in = 8'(i * 17);
            cycle();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            n_checks++;
            if (data_out !== 8'(i * 17) || data_out !== model_out) begin
                n_fail++;
                $display("FAIL sweep@%0d: got %h want %h", i, data_out, 8'(i * 17));
            end
        end
        do_write(3'd0, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want;
            want = (i == 0) ? 8'hFF : 8'(i * 17);
            do_read(3'(i));
            n_checks++;
            if (data_out !== want || data_out !== model_out) begin
                n_fail++;
                $display("FAIL rewrite@%0d: got %h want %h", i, data_out, want);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            wr_enb  = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            data_in = 8'($urandom);
            rd_enb  = 1'($urandom_range(0, 1));
            rd_addr = 3'($urandom_range(0, 7));
            cycle();
            n_checks++;
            if (data_out !== model_out) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", n, data_out, model_out);
            end
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_hold();
        test_async_reset();
        test_collision();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_8x8
